// File: rtl/hme_ip_tx_mti_reader.sv
// ============================================================================
// Module      : hme_ip_tx_mti_reader
// Description : TX read-side controller. Treats the 768x32 TX RAM as two
//               frame buffers served in strict alternation. It fetches words
//               from the ready buffer and serializes them little-endian onto
//               the MTI byte stream with sof/eof markers. When a frame has
//               been fully accepted, the buffer is released with a one-cycle
//               buf_done_o pulse.
//               Optional feature macro: HME_TX_MTI_PAD_EN (pads short frames
//               with 0x00 bytes up to 60 bytes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hme_ip_tx_mti_reader #(
  parameter int BUF_WORDS = 384,
  parameter int LEN_W     = 11
) (
  input  logic             clkr,
  input  logic             rstn,
  input  logic [1:0]       buf_vld_i,
  input  logic [LEN_W-1:0] len0_i,
  input  logic [LEN_W-1:0] len1_i,
  output logic [1:0]       buf_done_o,
  output logic             cer,
  output logic [9:0]       ar,
  output logic             rd_ram_sel,
  input  logic [31:0]      qr,
  output logic [7:0]       mti_data_o,
  output logic             mti_val_o,
  output logic             mti_sof_o,
  output logic             mti_eof_o,
  input  logic             mti_rdy_i
);

  localparam int               WP_W    = $clog2(BUF_WORDS);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(4 * BUF_WORDS);

`ifdef HME_TX_MTI_PAD_EN
  localparam logic             PAD_EN  = 1'b1;
`else
  localparam logic             PAD_EN  = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state_q;
  logic              cur_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bcnt_q;
  logic [WP_W-1:0]   wptr_q;
  logic              cer_q;
  logic              rvld_q;
  logic [31:0]       cur_word_q;
  logic [31:0]       nxt_word_q;
  logic [7:0]        data_q;
  logic              val_q;
  logic              sof_q;
  logic              eof_q;
  logic [1:0]        done_q;

  logic [LEN_W-1:0]  len_raw_d;
  logic [LEN_W-1:0]  len_in_d;
  logic [LEN_W-1:0]  nwords_d;
  logic [LEN_W-1:0]  tot_d;
  logic [LEN_W-1:0]  last_d;
  logic [LEN_W-1:0]  bnext_d;
  logic              more_d;
  logic              acc_d;
  logic [31:0]       src_word_d;
  logic [7:0]        nbyte_d;

  // Length selection/clipping, frame totals and next-byte selection
  always_comb begin
    len_raw_d  = cur_q ? len1_i : len0_i;
    len_in_d   = (len_raw_d > MAX_LEN) ? MAX_LEN : len_raw_d;
    nwords_d   = (len_q + LEN_W'(3)) >> 2;
`ifdef HME_TX_MTI_PAD_EN
    tot_d      = (len_q < LEN_W'(60)) ? LEN_W'(60) : len_q;
`else
    tot_d      = len_q;
`endif
    last_d     = tot_d - LEN_W'(1);
    bnext_d    = bcnt_q + LEN_W'(1);
    // Another data word remains beyond the most recently read one
    more_d     = (LEN_W'(wptr_q) + LEN_W'(1)) < nwords_d;
    acc_d      = val_q & mti_rdy_i;
    src_word_d = (bnext_d[1:0] == 2'b00) ? nxt_word_q : cur_word_q;
    nbyte_d    = src_word_d[{bnext_d[1:0], 3'b000} +: 8];
    // Bytes past the real frame length are pad bytes
    if (bnext_d >= len_q) begin
      nbyte_d = 8'h00;
    end
  end

  // Frame sequencing FSM with registered RAM and MTI outputs
  always_ff @(posedge clkr or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cur_q      <= 1'b0;
      len_q      <= '0;
      bcnt_q     <= '0;
      wptr_q     <= '0;
      cer_q      <= 1'b0;
      rvld_q     <= 1'b0;
      cur_word_q <= '0;
      nxt_word_q <= '0;
      data_q     <= '0;
      val_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= '0;
    end else begin
      done_q <= 2'b00;
      cer_q  <= 1'b0;
      rvld_q <= cer_q;
      case (state_q)
        S_IDLE: begin
          if (buf_vld_i[cur_q]) begin
            len_q  <= len_in_d;
            wptr_q <= '0;
            bcnt_q <= '0;
            if (len_in_d == '0) begin
              if (PAD_EN) begin
                // Zero-length frame becomes a full pad frame, no RAM reads
                data_q  <= 8'h00;
                val_q   <= 1'b1;
                sof_q   <= 1'b1;
                eof_q   <= 1'b0;
                state_q <= S_SEND;
              end else begin
                done_q[cur_q] <= 1'b1;
                state_q       <= S_DONE;
              end
            end else begin
              cer_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          cur_word_q <= qr;
          data_q     <= qr[7:0];
          val_q      <= 1'b1;
          sof_q      <= 1'b1;
          eof_q      <= (tot_d == LEN_W'(1));
          // Prefetch word 1 while word 0 is being presented
          if (more_d) begin
            wptr_q <= wptr_q + WP_W'(1);
            cer_q  <= 1'b1;
          end
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (rvld_q) begin
            nxt_word_q <= qr;
          end
          if (acc_d) begin
            if (bcnt_q == last_d) begin
              data_q        <= 8'h00;
              val_q         <= 1'b0;
              sof_q         <= 1'b0;
              eof_q         <= 1'b0;
              done_q[cur_q] <= 1'b1;
              state_q       <= S_DONE;
            end else begin
              bcnt_q <= bnext_d;
              data_q <= nbyte_d;
              sof_q  <= 1'b0;
              eof_q  <= (bnext_d == last_d);
              // Word boundary: prefetched word becomes current, fetch the next
              if (bnext_d[1:0] == 2'b00) begin
                cur_word_q <= nxt_word_q;
                if (more_d) begin
                  wptr_q <= wptr_q + WP_W'(1);
                  cer_q  <= 1'b1;
                end
              end
            end
          end
        end
        S_DONE: begin
          cur_q   <= ~cur_q;
          wptr_q  <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ar         = (cur_q ? 10'(BUF_WORDS) : 10'd0) + 10'(wptr_q);
  assign cer        = cer_q;
  assign rd_ram_sel = cur_q;
  assign buf_done_o = done_q;
  assign mti_data_o = data_q;
  assign mti_val_o  = val_q;
  assign mti_sof_o  = sof_q;
  assign mti_eof_o  = eof_q;

endmodule

`default_nettype wire

// File: tb/tb_hme_ip_tx_mti_reader.sv
// ============================================================================
// Module      : tb_hme_ip_tx_mti_reader
// Description : Scoreboard bench for hme_ip_tx_mti_reader with a RAM model,
//               a host model releasing buffers on buf_done_o, and a MAC model
//               with selectable ready patterns.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hme_ip_tx_mti_reader;

`ifdef HME_TX_MTI_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clkr;
  logic        rstn;
  logic [1:0]  buf_vld;
  logic [10:0] len0, len1;
  logic [1:0]  buf_done;
  logic        cer;
  logic [9:0]  ar;
  logic        rd_ram_sel;
  logic [31:0] qr;
  logic [7:0]  mti_data;
  logic        mti_val, mti_sof, mti_eof;
  logic        rdy;

  hme_ip_tx_mti_reader #(.BUF_WORDS(384), .LEN_W(11)) dut (
    .clkr       (clkr),
    .rstn       (rstn),
    .buf_vld_i  (buf_vld),
    .len0_i     (len0),
    .len1_i     (len1),
    .buf_done_o (buf_done),
    .cer        (cer),
    .ar         (ar),
    .rd_ram_sel (rd_ram_sel),
    .qr         (qr),
    .mti_data_o (mti_data),
    .mti_val_o  (mti_val),
    .mti_sof_o  (mti_sof),
    .mti_eof_o  (mti_eof),
    .mti_rdy_i  (rdy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem [0:767];
  logic [9:0]  exp_bytes [$];
  logic [9:0]  exp_reads [$];
  int          exp_done [$];

  int arm [2];
  int rel [2];
  int done_cnt = 0;
  int acc_cnt = 0;
  int cer_cnt = 0;
  int ndone_exp = 0;
  int rdy_mode = 0;
  int turn = 0;

  logic        prev_stall;
  logic [10:0] held;
  logic        in_frame;

  assign buf_vld = {arm[1] != rel[1], arm[0] != rel[0]};

  initial clkr = 1'b0;
  always #5 clkr = ~clkr;

  // RAM: registered read, data valid one clock after cer
  always @(posedge clkr) begin
    if (cer) qr <= mem[ar];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // MAC ready pattern
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clkr);
      #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: reads, bytes, stall hold, bubbles and release pulses
  always @(negedge clkr) begin
    logic [9:0] e;
    int d;
    if (!rstn) begin
      prev_stall = 1'b0;
      in_frame   = 1'b0;
    end else begin
      if (cer) begin
        cer_cnt++;
        if (exp_reads.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = exp_reads.pop_front();
          chk("ram_addr", ar, e);
          chk("ram_sel", rd_ram_sel, e >= 10'd384);
        end
      end
      if (prev_stall) chk("stall_hold", {mti_val, mti_sof, mti_eof, mti_data}, held);
      if (in_frame) chk("no_bubble", mti_val, 1);
      if (mti_val && rdy) begin
        acc_cnt++;
        if (exp_bytes.size() == 0) chk("unexpected_byte", 1, 0);
        else begin
          e = exp_bytes.pop_front();
          chk("mti_byte", {mti_sof, mti_eof, mti_data}, e);
        end
        in_frame = !mti_eof;
      end
      prev_stall = mti_val && !rdy;
      held = {mti_val, mti_sof, mti_eof, mti_data};
      if (buf_done != 2'b00) begin
        done_cnt++;
        if (exp_done.size() == 0) chk("unexpected_done", buf_done, 0);
        else begin
          d = exp_done.pop_front();
          chk("buf_done", buf_done, 2'b01 << d);
        end
        if (buf_done[0]) rel[0]++;
        if (buf_done[1]) rel[1]++;
      end
    end
  end

  // Reference model: expected reads, byte stream and release for one frame
  task automatic prep(input int b, input int len, input bit pat);
    int base, lenc, nw, tot;
    logic [31:0] w;
    logic [7:0]  by;
    base = b * 384;
    lenc = (len > 1536) ? 1536 : len;
    nw   = (lenc + 3) / 4;
    tot  = (PAD && lenc < 60) ? 60 : lenc;
    for (int i = 0; i < 384; i++)
      mem[base + i] = pat ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom;
    if (b == 0) len0 = 11'(len); else len1 = 11'(len);
    for (int i = 0; i < nw; i++) exp_reads.push_back(10'(base + i));
    for (int i = 0; i < tot; i++) begin
      w  = mem[base + i / 4];
      by = (i < lenc) ? 8'(w >> (8 * (i % 4))) : 8'h00;
      exp_bytes.push_back({i == 0, i == tot - 1, by});
    end
    exp_done.push_back(b);
    ndone_exp++;
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt < ndone_exp && k < 20000) begin
      @(posedge clkr);
      k++;
    end
    chk("done_timeout", done_cnt >= ndone_exp, 1);
    repeat (3) @(posedge clkr);
    chk("bytes_drained", exp_bytes.size(), 0);
    chk("reads_drained", exp_reads.size(), 0);
  endtask

  task automatic frame(input int len);
    prep(turn, len, 1'b0);
    @(posedge clkr);
    #1;
    arm[turn]++;
    turn ^= 1;
    wait_done();
  endtask

  task automatic chk_reset();
    chk("rst_cer", cer, 0);
    chk("rst_ar", ar, 0);
    chk("rst_sel", rd_ram_sel, 0);
    chk("rst_data", mti_data, 0);
    chk("rst_val", mti_val, 0);
    chk("rst_sof", mti_sof, 0);
    chk("rst_eof", mti_eof, 0);
    chk("rst_done", buf_done, 0);
  endtask

  initial begin
    int a0, k;
    rstn = 1'b0;
    len0 = '0;
    len1 = '0;
    arm[0] = 0; arm[1] = 0; rel[0] = 0; rel[1] = 0;
    repeat (3) @(posedge clkr);
    @(negedge clkr);
    chk_reset();
    @(posedge clkr);
    #1 rstn = 1'b1;

    // Only buffer 1 ready: reader must keep waiting on buffer 0
    len1 = 11'd1518;
    arm[1]++;
    repeat (20) @(posedge clkr);
    chk("no_read_buf1_only", cer_cnt, 0);
    chk("no_val_buf1_only", mti_val, 0);

    // Buffer 0 pattern frame with start-up latency, then buffer 1 follows
    prep(0, 64, 1'b1);
    prep(1, 1518, 1'b0);
    @(posedge clkr);
    #1 arm[0]++;
    @(posedge clkr);
    @(posedge clkr);
    @(negedge clkr);
    chk("latency_val_e1", mti_val, 0);
    @(posedge clkr);
    @(negedge clkr);
    chk("latency_sof_e2", {mti_val, mti_sof}, 2'b11);
    wait_done();

    // Both buffers ready at once: strict alternation from buffer 0
    prep(0, 5, 1'b0);
    prep(1, 300, 1'b0);
    @(posedge clkr);
    #1;
    arm[0]++;
    arm[1]++;
    wait_done();

    rdy_mode = 1; frame(9);
    rdy_mode = 2; frame(42);
    rdy_mode = 0; frame(0);
    frame(1);
    frame(1600);
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) frame(int'($urandom_range(0, 200)));

    // Reset in the middle of a frame
    rdy_mode = 0;
    prep(turn, 100, 1'b0);
    a0 = acc_cnt;
    @(posedge clkr);
    #1 arm[turn]++;
    k = 0;
    while (acc_cnt < a0 + 10 && k < 500) begin
      @(posedge clkr);
      k++;
    end
    chk("midframe_progress", acc_cnt >= a0 + 10, 1);
    @(posedge clkr);
    #1 rstn = 1'b0;
    arm[0] = rel[0];
    arm[1] = rel[1];
    exp_bytes.delete();
    exp_reads.delete();
    exp_done.delete();
    ndone_exp = done_cnt;
    @(negedge clkr);
    chk_reset();
    @(posedge clkr);
    #1 rstn = 1'b1;
    turn = 0;
    repeat (8) @(posedge clkr);
    chk("no_done_after_reset", done_cnt, ndone_exp);
    frame(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
